// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: DBIT data bits LSB first, SB_TICK ticks of stop bit.
// Optional parity state and parity_err port enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_r, state_n;
  logic [1:0]        sync_r;
  logic              rx_s;
  logic [SW-1:0]     s_r, s_n;
  logic [NW-1:0]     n_r, n_n;
  logic [DBIT-1:0]   b_r, b_n;
  logic [7:0]        dout_n;
  logic              done_n;
  logic              ferr_n;
`ifdef UART_RX_PARITY_EN
  logic              par_r, par_n;
  logic              perr_n;
`endif

  function automatic logic [7:0] widen(input logic [DBIT-1:0] v);
    logic [7:0] w;
    w = 8'd0;
    w[DBIT-1:0] = v;
    return w;
  endfunction

`ifdef UART_RX_PARITY_EN
  // Nonzero result means the received parity bit disagrees with the data.
  function automatic logic parity_mismatch(input logic [DBIT-1:0] d, input logic p);
    return (^d) ^ p ^ ((PARITY_ODD != 0) ? 1'b1 : 1'b0);
  endfunction
`endif

  assign rx_s = sync_r[1];

  // Two-flop synchronizer; idle-high so reset does not look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      s_r          <= '0;
      n_r          <= '0;
      b_r          <= '0;
      dout         <= 8'd0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state_r      <= state_n;
      s_r          <= s_n;
      n_r          <= n_n;
      b_r          <= b_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_r        <= par_n;
      parity_err   <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state_r;
    s_n     = s_r;
    n_n     = n_r;
    b_n     = b_r;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_r;
    perr_n  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        // A tick coinciding with the falling edge is deliberately not counted.
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == S_MID) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s_r + SW'(1);
          end
        end else begin
          s_n = s_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            b_n = {rx_s, b_r[DBIT-1:1]};
            s_n = '0;
            if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n_r + NW'(1);
            end
          end else begin
            s_n = s_r + SW'(1);
          end
        end else begin
          s_n = s_r;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_r == S_LAST) begin
            par_n   = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s_r + SW'(1);
          end
        end else begin
          s_n = s_r;
        end
      end
`endif
      STOP: begin
        // The byte is delivered even when the stop bit is low.
        if (s_tick) begin
          if (s_r == S_STOP) begin
            state_n = IDLE;
            done_n  = 1'b1;
            dout_n  = widen(b_r);
            ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_n  = parity_mismatch(b_r, par_r);
`endif
          end else begin
            s_n = s_r + SW'(1);
          end
        end else begin
          s_n = s_r;
        end
      end
      default: begin
        state_n = IDLE;
        s_n     = '0;
        n_n     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: s_tick every 4 clocks, so one bit lasts 64 clocks.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       s_tick;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
    .parity_err   (parity_err),
`endif
    .frame_err    (frame_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       lat;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Output monitor: pops one expectation per done pulse.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_done) check("done_width", int'(rx_done_tick), 0);
      if (rx_done_tick) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("dout", int'(dout), int'(e.d));
          check("frame_err", int'(frame_err), int'(e.fe));
`ifdef UART_RX_PARITY_EN
          check("parity_err", int'(parity_err), int'(e.pe));
`endif
          if (e.lat) check("latency_window", int'((cyc - e.start) >= 600 && (cyc - e.start) <= 630), 1);
        end
      end
      prev_done = rx_done_tick;
    end
  end

  task automatic hold_bit(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // abort_bit >= 0: pulse reset halfway through that data bit instead of finishing.
  task automatic send_frame(input logic [7:0] d, input logic stop_low, input logic pbit,
                            input logic lat, input int abort_bit);
    exp_t e;
    e.d = d; e.fe = stop_low; e.pe = (^d) ^ pbit; e.lat = lat; e.start = cyc;
    if (abort_bit < 0) sb.push_back(e);
    hold_bit(1'b0, 64);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        hold_bit(d[i], 32);
        rst = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("rst_dout", int'(dout), 0);
          check("rst_done", int'(rx_done_tick), 0);
          check("rst_ferr", int'(frame_err), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        hold_bit(1'b1, 200);
        return;
      end
      hold_bit(d[i], 64);
    end
`ifdef UART_RX_PARITY_EN
    hold_bit(pbit, 64);
`endif
    if (stop_low) begin
      hold_bit(1'b0, 48);
      hold_bit(1'b1, 16);
    end else begin
      hold_bit(1'b1, 64);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dout", int'(dout), 0);
    check("reset_done", int'(rx_done_tick), 0);
    check("reset_ferr", int'(frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    hold_bit(1'b1, 50);

    send_frame(8'hA5, 1'b0, ^8'hA5, 1'b1, -1);
    wait_drain();

    send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, -1);
    wait_drain();

    hold_bit(1'b0, 20);
    hold_bit(1'b1, 200);
    check("glitch_dout_held", int'(dout), 'hFF);
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, -1);
    wait_drain();

    send_frame(8'h55, 1'b1, ^8'h55, 1'b0, -1);
    wait_drain();
    hold_bit(1'b1, 100);

    send_frame(8'h81, 1'b0, ^8'h81, 1'b0, 4);
    send_frame(8'h81, 1'b0, ^8'h81, 1'b0, -1);
    wait_drain();

    send_frame(8'h6E, 1'b0, ^8'h6E, 1'b0, -1);
    wait_drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0, -1);
    wait_drain();
`endif

    hold_bit(1'b1, 200);
    check("sb_empty_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
